// File: rtl/modmul_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : modmul_arbiter
//  Purpose  : Shares one pipelined Modmul among NREQ requesters and steers each
//             result back to the requester that issued it.
//             Define MODMUL_ARB_RR_EN for round-robin arbitration; otherwise
//             the lowest requesting index wins.
//  Revision : 1.0  initial release
// ============================================================================
module modmul_arbiter #(
    parameter int NREQ = 4,
    parameter int LAT  = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 en,
    input  logic [NREQ-1:0]      req_valid,
    input  logic [12*NREQ-1:0]   req_a,
    input  logic [12*NREQ-1:0]   req_b,
    output logic [NREQ-1:0]      req_ready,
    output logic [11:0]          mm_a,
    output logic [11:0]          mm_b,
    input  logic [11:0]          mm_r,
    output logic [NREQ-1:0]      rsp_valid,
    output logic [11:0]          rsp_r,
    output logic                 idle
);

    localparam int C_IDXW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int C_CNTW = $clog2(LAT + 1);

    logic [C_IDXW-1:0] r_ptr;
    logic [C_IDXW-1:0] w_ptr_nxt;
    logic [C_IDXW-1:0] w_gidx;
    logic [C_IDXW-1:0] w_cidx;
    logic              w_found;
    logic              w_arb_en;
    logic [LAT-1:0]    r_pv;
    logic [C_IDXW-1:0] r_pi [LAT];
    logic [C_CNTW-1:0] r_cnt;
    logic              w_rsp;

    // Grants are held off while reset is asserted so idle reads 1 throughout.
    assign w_arb_en = en & rst_n;

    // Circular search starting at the pointer; the fixed-priority build keeps
    // the pointer at 0, which turns this into a lowest-index-wins search.
    always_comb begin
        w_found = 1'b0;
        w_gidx  = '0;
        w_cidx  = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (int'(r_ptr) + k >= NREQ) begin
                w_cidx = C_IDXW'(int'(r_ptr) + k - NREQ);
            end else begin
                w_cidx = C_IDXW'(int'(r_ptr) + k);
            end
            if (!w_found && w_arb_en && req_valid[w_cidx]) begin
                w_found = 1'b1;
                w_gidx  = w_cidx;
            end
        end
    end

    always_comb begin
        req_ready = '0;
        if (w_found) begin
            req_ready[w_gidx] = 1'b1;
        end
    end

    always_comb begin
        mm_a = '0;
        mm_b = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (req_ready[k]) begin
                mm_a = req_a[12*k +: 12];
                mm_b = req_b[12*k +: 12];
            end
        end
    end

    always_comb begin
`ifdef MODMUL_ARB_RR_EN
        w_ptr_nxt = r_ptr;
        if (w_found) begin
            w_ptr_nxt = (w_gidx == C_IDXW'(NREQ - 1)) ? '0 : w_gidx + C_IDXW'(1);
        end
`else
        w_ptr_nxt = '0;
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr <= '0;
        end else begin
            r_ptr <= w_ptr_nxt;
        end
    end

    // Tag pipeline tracks the Modmul latency so each result finds its owner.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pv <= '0;
            for (int s = 0; s < LAT; s++) begin
                r_pi[s] <= '0;
            end
        end else begin
            r_pv[0] <= w_found;
            r_pi[0] <= w_gidx;
            for (int s = 1; s < LAT; s++) begin
                r_pv[s] <= r_pv[s-1];
                r_pi[s] <= r_pi[s-1];
            end
        end
    end

    assign w_rsp = r_pv[LAT-1];

    always_comb begin
        rsp_valid = '0;
        if (w_rsp) begin
            rsp_valid[r_pi[LAT-1]] = 1'b1;
        end
    end

    assign rsp_r = w_rsp ? mm_r : 12'd0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else begin
            case ({w_found, w_rsp})
                2'b10:   r_cnt <= r_cnt + C_CNTW'(1);
                2'b01:   r_cnt <= r_cnt - C_CNTW'(1);
                default: r_cnt <= r_cnt;
            endcase
        end
    end

    assign idle = (r_cnt == '0) && !w_found;

endmodule
`default_nettype wire

// File: doc/modmul_arbiter.md
MODMUL_ARBITER -- requirements
Module: modmul_arbiter

Interface
REQ-001 Parameter NREQ, default 4, is the number of requesters sharing one Modmul instance (legal 2..8).
REQ-002 Parameter LAT, default 2, is the Modmul clk-to-result latency in cycles (legal 1..4); it SHALL match the instantiated Modmul build.
REQ-003 clk  input  1  is the single clock; all state changes on its rising edge.
REQ-004 rst_n  input  1  is the asynchronous active-low reset.
REQ-005 en  input  1  enables new grants; when low, in-flight operations still drain.
REQ-006 req_valid  input  NREQ  is the per-requester operand-valid flag.
REQ-007 req_a, req_b  input  12*NREQ  are the packed operands; requester i occupies bits [12i+11:12i].
REQ-008 req_ready  output  NREQ  is the one-hot grant; a transfer occurs when req_valid[i] and req_ready[i] are both high.
REQ-009 mm_a, mm_b  output  12 each  are the operands driven to the shared Modmul.
REQ-010 mm_r  input  12  is the Modmul result, valid LAT cycles after the operands.
REQ-011 rsp_valid  output  NREQ  is the one-hot result strobe, 1 cycle wide per result.
REQ-012 rsp_r  output  12  is the result; it SHALL equal mm_r whenever any rsp_valid bit is high.
REQ-013 idle  output  1  SHALL be high when no operation is in flight and no grant is issued this cycle.

Function
REQ-014 At most one req_ready bit SHALL be high per cycle; it is combinational from req_valid, en and the priority pointer.
REQ-015 req_ready SHALL be all-zero when en is low or req_valid is all-zero.
REQ-016 A granted requester's operands SHALL drive mm_a/mm_b in the grant cycle; with no grant, mm_a/mm_b SHALL be 0.
REQ-017 The block SHALL keep an LAT-deep shift register of {valid, requester index}; each grant inserts {1, i}, and no grant inserts {0, x}.
REQ-018 When the tail entry is valid, rsp_valid[index] SHALL pulse exactly LAT cycles after the grant cycle.
REQ-019 One grant is allowed per cycle. Throughput is 1 operation/cycle. There is no response backpressure, and requesters SHALL accept rsp_valid unconditionally.
REQ-020 Results SHALL return in grant order; back-to-back grants from the same requester SHALL produce back-to-back responses.
REQ-021 An in-flight counter (width clog2(LAT+1)) SHALL increment on a grant without a response, decrement on a response without a grant, and hold when both or neither occur.
REQ-022 idle SHALL be high exactly when the in-flight counter is 0 and req_ready is all-zero.
REQ-023 When en falls, operations already granted SHALL still complete and produce their rsp_valid pulses.

Reset
REQ-024 While rst_n is low: the pipeline valid bits, the in-flight counter and the priority pointer SHALL be 0; rsp_valid is 0, rsp_r is 0 and idle is 1.
REQ-025 Reset asserted mid-operation SHALL discard all in-flight operations; no rsp_valid SHALL pulse for them after reset release.
REQ-026 The first grant can occur in the first clock edge after rst_n deasserts.

Configuration
REQ-027 Macro MODMUL_ARB_RR_EN selects the arbitration policy.
REQ-028 When MODMUL_ARB_RR_EN is defined, arbitration is round-robin. The pointer SHALL advance to (granted index + 1) mod NREQ after each grant; the search starts at the pointer and wraps from NREQ-1 to 0.
REQ-029 When MODMUL_ARB_RR_EN is not defined, arbitration is fixed priority: the lowest asserted index wins and the pointer is unused (held at 0).

Verification
REQ-030 NREQ=4, LAT=2, RR build, req_valid=4'b1111 held for 8 cycles: req_ready SHALL sequence 0001,0010,0100,1000,0001,... and rsp_valid SHALL follow the same sequence delayed 2 cycles.
REQ-031 Fixed-priority build, req_valid=4'b1010 held: req_ready SHALL be 0010 every cycle and requester 3 SHALL never be granted.
REQ-032 Requester 2 sends a=3328, b=3328 with a Modmul model at q=3329: rsp_valid=0100 SHALL pulse 2 cycles later with rsp_r=1.
REQ-033 Grant issued on 3 consecutive cycles, then en=0: no further req_ready; 3 rsp_valid pulses SHALL follow; idle SHALL return to 1 after the last pulse.
REQ-034 Assert rst_n=0 one cycle after a grant: rsp_valid SHALL stay 0 through and after reset, and idle SHALL be 1.
REQ-035 Random req_valid for 10k cycles: a scoreboard SHALL confirm every grant yields exactly one response to the same requester with the correct product mod 3329, in order, and never more than one req_ready bit high.
